// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: pops words from the FIFO storage into a registered valid/ready output,
// pulsing the occupancy counter's count-down input once per word popped.
module fifo_read_ctrl #(
    parameter int DATA_W = 8,
    parameter int PTR_W  = 2
) (
    input  logic              CLK,
    input  logic              FIFOREAD_RST,
    input  logic [PTR_W-1:0]  FIFOREAD_Count,
    input  logic              FIFOREAD_Inhibit,
    input  logic [DATA_W-1:0] FIFOREAD_MemData,
    output logic [PTR_W-1:0]  FIFOREAD_RdAddr,
    output logic              FIFOREAD_PopSignal,
    output logic [DATA_W-1:0] FIFOREAD_Data,
    output logic              FIFOREAD_Valid,
    input  logic              FIFOREAD_Ready
);
    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HOLD = 2'd2} state_t;
    state_t state, nextState;
    logic nextValid, doPop, canPop;
    logic [PTR_W-1:0] nextAddr;
    logic [DATA_W-1:0] nextData;
    assign canPop = (FIFOREAD_Count != '0) && !FIFOREAD_Inhibit;
    // SETTLE never pops: the count it sees has not yet absorbed the previous pop.
    always_comb begin
        doPop = 1'b0;
        nextState = state;
        nextValid = FIFOREAD_Valid;
        case (state)
            IDLE: begin
                doPop = canPop;
                nextValid = 1'b0;
            end
            SETTLE: begin
                nextState = FIFOREAD_Ready ? IDLE : HOLD;
                nextValid = !FIFOREAD_Ready;
            end
            HOLD: begin
                doPop = FIFOREAD_Ready && canPop;
                nextState = FIFOREAD_Ready ? IDLE : HOLD;
                nextValid = !FIFOREAD_Ready;
            end
            default: begin
                nextState = IDLE;
                nextValid = 1'b0;
            end
        endcase
        if (doPop) begin
            nextState = SETTLE;
            nextValid = 1'b1;
        end
        nextAddr = doPop ? FIFOREAD_RdAddr + 1'b1 : FIFOREAD_RdAddr;
        nextData = doPop ? FIFOREAD_MemData : FIFOREAD_Data;
    end
    always_ff @(posedge CLK) begin
        if (FIFOREAD_RST) begin
            state <= IDLE;
            FIFOREAD_Valid <= 1'b0;
            FIFOREAD_PopSignal <= 1'b0;
            FIFOREAD_RdAddr <= '0;
            FIFOREAD_Data <= '0;
        end else begin
            state <= nextState;
            FIFOREAD_Valid <= nextValid;
            FIFOREAD_PopSignal <= doPop;
            FIFOREAD_RdAddr <= nextAddr;
            FIFOREAD_Data <= nextData;
        end
    end
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb_fifo_read_ctrl: drives fifo_read_ctrl against a small storage/occupancy-counter model
// and scores accepted words against the order they were pushed.
module tb_fifo_read_ctrl;
    logic CLK = 1'b0;
    logic rst, modelRst, inhibit, ready, push, pop, valid;
    logic [1:0] count, wp, rdAddr;
    logic [7:0] memData, data, wdata;
    logic [7:0] mem [4];
    logic [7:0] expQ[$];
    logic [7:0] gotQ[$];
    logic [1:0] addrQ[$];
    int checks = 0, errors = 0, pulses = 0, gi = 0;

    fifo_read_ctrl #(.DATA_W(8), .PTR_W(2)) dut (
        .CLK(CLK), .FIFOREAD_RST(rst), .FIFOREAD_Count(count), .FIFOREAD_Inhibit(inhibit),
        .FIFOREAD_MemData(memData), .FIFOREAD_RdAddr(rdAddr), .FIFOREAD_PopSignal(pop),
        .FIFOREAD_Data(data), .FIFOREAD_Valid(valid), .FIFOREAD_Ready(ready)
    );

    always #5 CLK = ~CLK;
    assign memData = mem[rdAddr];

    // Write side and occupancy counter: push and pop net out in the same edge.
    always @(posedge CLK) begin
        if (modelRst) begin
            count <= 2'd0;
            wp <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= wdata;
                wp <= wp + 2'd1;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // Inputs only change just after posedge, so a negedge Valid&&Ready means acceptance at the next edge.
    always @(negedge CLK) begin
        if (!rst) begin
            if (valid && ready) gotQ.push_back(data);
            if (pop) begin
                pulses++;
                addrQ.push_back(rdAddr - 2'd1);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        push = 1'b1;
        wdata = d;
        expQ.push_back(d);
        cyc(1);
        push = 1'b0;
    endtask

    task automatic sys_reset;
        rst = 1'b1;
        modelRst = 1'b1;
        ready = 1'b0;
        inhibit = 1'b0;
        push = 1'b0;
        cyc(2);
        rst = 1'b0;
        modelRst = 1'b0;
        expQ.delete();
    endtask

    task automatic test_reset;
        logic [7:0] e;
        sys_reset();
        inhibit = 1'b1;
        push_word(8'h01); push_word(8'h02); push_word(8'h03);
        rst = 1'b1;
        inhibit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc(1);
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h want 0", valid); end
            checks++; if (pop !== 1'b0) begin errors++; $display("FAIL rst_pop got %0h want 0", pop); end
            checks++; if (rdAddr !== 2'd0) begin errors++; $display("FAIL rst_addr got %0h want 0", rdAddr); end
            checks++; if (data !== 8'h00) begin errors++; $display("FAIL rst_data got %0h want 0", data); end
        end
        rst = 1'b0;
        cyc(1);
        checks++; if (pop !== 1'b1) begin errors++; $display("FAIL rst_first_pop got %0h want 1", pop); end
        checks++; if (data !== 8'h01) begin errors++; $display("FAIL rst_first_data got %0h want 01", data); end
        ready = 1'b1;
        cyc(6);
        while (expQ.size() != 0) begin
            e = expQ.pop_front();
            checks++;
            if (gi >= gotQ.size()) begin errors++; $display("FAIL rst_word missing want %0h", e); end
            else if (gotQ[gi] !== e) begin errors++; $display("FAIL rst_word got %0h want %0h", gotQ[gi], e); end
            gi++;
        end
        checks++; if (gotQ.size() != gi) begin errors++; $display("FAIL rst_extra got %0d want %0d", gotQ.size(), gi); end
    endtask

    task automatic test_single;
        int p0;
        logic [7:0] e;
        sys_reset();
        ready = 1'b1;
        p0 = pulses;
        push_word(8'hA5);
        cyc(1);
        checks++; if (data !== 8'hA5) begin errors++; $display("FAIL single_data got %0h want a5", data); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0h want 1", valid); end
        checks++; if (pop !== 1'b1) begin errors++; $display("FAIL single_pop got %0h want 1", pop); end
        checks++; if (rdAddr !== 2'd1) begin errors++; $display("FAIL single_addr got %0h want 1", rdAddr); end
        cyc(1);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_valid_off got %0h want 0", valid); end
        checks++; if (pop !== 1'b0) begin errors++; $display("FAIL single_pop_off got %0h want 0", pop); end
        cyc(3);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL empty_valid got %0h want 0", valid); end
        checks++; if (pulses - p0 != 1) begin errors++; $display("FAIL empty_pulses got %0d want 1", pulses - p0); end
        while (expQ.size() != 0) begin
            e = expQ.pop_front();
            checks++;
            if (gi >= gotQ.size()) begin errors++; $display("FAIL single_word missing want %0h", e); end
            else if (gotQ[gi] !== e) begin errors++; $display("FAIL single_word got %0h want %0h", gotQ[gi], e); end
            gi++;
        end
    endtask

    task automatic test_backpressure;
        int p0;
        logic [7:0] e;
        sys_reset();
        inhibit = 1'b1;
        push_word(8'h31); push_word(8'h32); push_word(8'h33);
        inhibit = 1'b0;
        p0 = pulses;
        cyc(1);
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            checks++; if (data !== 8'h31 || valid !== 1'b1) begin errors++; $display("FAIL bp_hold got %0h/%0h want 31/1", data, valid); end
        end
        checks++; if (pulses - p0 != 1) begin errors++; $display("FAIL bp_pulses got %0d want 1", pulses - p0); end
        ready = 1'b1;
        cyc(1);
        checks++; if (data !== 8'h32 || pop !== 1'b1 || valid !== 1'b1) begin errors++; $display("FAIL bp_b2b got %0h/%0h/%0h want 32/1/1", data, pop, valid); end
        checks++; if (rdAddr !== 2'd2) begin errors++; $display("FAIL bp_addr got %0h want 2", rdAddr); end
        cyc(6);
        while (expQ.size() != 0) begin
            e = expQ.pop_front();
            checks++;
            if (gi >= gotQ.size()) begin errors++; $display("FAIL bp_word missing want %0h", e); end
            else if (gotQ[gi] !== e) begin errors++; $display("FAIL bp_word got %0h want %0h", gotQ[gi], e); end
            gi++;
        end
        checks++; if (gotQ.size() != gi) begin errors++; $display("FAIL bp_extra got %0d want %0d", gotQ.size(), gi); end
    endtask

    task automatic test_wrap;
        int p0, a0;
        logic [7:0] e;
        logic [7:0] words [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        logic [1:0] addrs [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        sys_reset();
        ready = 1'b1;
        p0 = pulses;
        a0 = addrQ.size();
        for (int i = 0; i < 6; i++) begin
            push_word(words[i]);
            cyc(1);
        end
        cyc(4);
        checks++; if (pulses - p0 != 6) begin errors++; $display("FAIL wrap_pulses got %0d want 6", pulses - p0); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (a0 + i >= addrQ.size()) begin errors++; $display("FAIL wrap_addr missing want %0h", addrs[i]); end
            else if (addrQ[a0 + i] !== addrs[i]) begin errors++; $display("FAIL wrap_addr got %0h want %0h", addrQ[a0 + i], addrs[i]); end
        end
        while (expQ.size() != 0) begin
            e = expQ.pop_front();
            checks++;
            if (gi >= gotQ.size()) begin errors++; $display("FAIL wrap_word missing want %0h", e); end
            else if (gotQ[gi] !== e) begin errors++; $display("FAIL wrap_word got %0h want %0h", gotQ[gi], e); end
            gi++;
        end
        checks++; if (gotQ.size() != gi) begin errors++; $display("FAIL wrap_extra got %0d want %0d", gotQ.size(), gi); end
    endtask

    task automatic test_inhibit;
        int p0;
        logic [7:0] e;
        sys_reset();
        inhibit = 1'b1;
        push_word(8'h51); push_word(8'h52); push_word(8'h53);
        inhibit = 1'b0;
        cyc(2);
        inhibit = 1'b1;
        ready = 1'b1;
        p0 = pulses;
        cyc(1);
        checks++; if (valid !== 1'b0 || pop !== 1'b0) begin errors++; $display("FAIL inh_accept got %0h/%0h want 0/0", valid, pop); end
        cyc(3);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL inh_idle got %0h want 0", valid); end
        checks++; if (pulses - p0 != 0) begin errors++; $display("FAIL inh_pulses got %0d want 0", pulses - p0); end
        inhibit = 1'b0;
        cyc(1);
        checks++; if (pop !== 1'b1 || valid !== 1'b1 || data !== 8'h52) begin errors++; $display("FAIL inh_resume got %0h/%0h/%0h want 1/1/52", pop, valid, data); end
        cyc(6);
        while (expQ.size() != 0) begin
            e = expQ.pop_front();
            checks++;
            if (gi >= gotQ.size()) begin errors++; $display("FAIL inh_word missing want %0h", e); end
            else if (gotQ[gi] !== e) begin errors++; $display("FAIL inh_word got %0h want %0h", gotQ[gi], e); end
            gi++;
        end
        checks++; if (gotQ.size() != gi) begin errors++; $display("FAIL inh_extra got %0d want %0d", gotQ.size(), gi); end
    endtask

    task automatic test_reset_midop;
        sys_reset();
        push_word(8'h61);
        cyc(1);
        checks++; if (valid !== 1'b1 || pop !== 1'b1) begin errors++; $display("FAIL mid_settle got %0h/%0h want 1/1", valid, pop); end
        rst = 1'b1;
        modelRst = 1'b1;
        cyc(1);
        checks++; if (valid !== 1'b0 || pop !== 1'b0) begin errors++; $display("FAIL mid_flags got %0h/%0h want 0/0", valid, pop); end
        checks++; if (rdAddr !== 2'd0 || data !== 8'h00) begin errors++; $display("FAIL mid_regs got %0h/%0h want 0/0", rdAddr, data); end
        rst = 1'b0;
        modelRst = 1'b0;
        expQ.delete();
        cyc(2);
        checks++; if (valid !== 1'b0 || pop !== 1'b0) begin errors++; $display("FAIL mid_idle got %0h/%0h want 0/0", valid, pop); end
    endtask

    initial begin
        rst = 1'b1;
        modelRst = 1'b1;
        inhibit = 1'b0;
        ready = 1'b0;
        push = 1'b0;
        wdata = 8'h00;
        test_reset();
        test_single();
        test_backpressure();
        test_wrap();
        test_inhibit();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
